// File: rtl/alu_ctrl_defs.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_defs (package)
// Description : Op codes and controller state encoding shared by the
//               bit-serial ALU sequencer and its one-bit slice.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_defs;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Ops whose signed overflow is meaningful.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_1.sv
`default_nettype none
// ============================================================================
// Module      : alu_1
// Description : One-bit MIPS ALU slice. alu_op[2] inverts b; alu_op[1:0]
//               selects AND / OR / SUM / XOR. Carry is always produced.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_1 (
  input  logic       a,
  input  logic       b,
  input  logic       carry_in,
  input  logic [2:0] alu_op,
  output logic       result,
  output logic       carry_out
);

  logic w_b;
  logic w_sum;

  assign w_b       = b ^ alu_op[2];
  assign w_sum     = a ^ w_b ^ carry_in;
  assign carry_out = (a & w_b) | (a & carry_in) | (w_b & carry_in);

  // Function select on the low op bits.
  always_comb begin
    result = 1'b0;
    case (alu_op[1:0])
      2'b00:   result = a & w_b;
      2'b01:   result = a | w_b;
      2'b10:   result = w_sum;
      default: result = a ^ w_b;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_ctrl
// Description : Bit-serial sequencer driving one alu_1 slice for WIDTH cycles,
//               LSB first, to perform a full-width MIPS ALU operation.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_ctrl
  import alu_ctrl_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int               IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_result;
  logic [2:0]         r_op;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_carry_out;
  logic               r_overflow;

  logic               w_accept;
  logic               w_last;
  logic [2:0]         w_slice_op;
  logic               w_slice_res;
  logic               w_slice_cout;
  logic               w_c_msb;
  logic               w_ovf;

  // Operands are shifted right so the active bit is always at position 0.
  assign w_slice_op = (r_op == ALU_SLT) ? ALU_SUB : r_op;
  assign w_accept   = start && (r_state != S_RUN);
  assign w_last     = (r_state == S_RUN) && (r_idx == LAST_IDX);
  assign w_c_msb    = r_carry;
  assign w_ovf      = w_c_msb ^ w_slice_cout;

  alu_1 u_slice (
    .a         (r_a_sh[0]),
    .b         (r_b_sh[0]),
    .carry_in  (r_carry),
    .alu_op    (w_slice_op),
    .result    (w_slice_res),
    .carry_out (w_slice_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and status outputs.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next_state = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next_state = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = start ? S_RUN : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand latch, serial stepping, result assembly and final flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_op        <= ALU_AND;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_op    <= op;
      r_idx   <= '0;
      r_carry <= op[2];
    end else if (r_state == S_RUN) begin
      r_a_sh  <= r_a_sh >> 1;
      r_b_sh  <= r_b_sh >> 1;
      r_carry <= w_slice_cout;
      r_idx   <= r_idx + IDX_W'(1);
      if (w_last) begin
        r_carry_out <= w_slice_cout;
        r_overflow  <= is_arith(r_op) && (r_op != ALU_SLT) && w_ovf;
        if (r_op == ALU_SLT)
          r_result <= {{(WIDTH-1){1'b0}}, w_slice_res ^ w_ovf};
        else
          r_result <= {w_slice_res, r_result[WIDTH-1:1]};
      end else begin
        r_result <= {w_slice_res, r_result[WIDTH-1:1]};
      end
    end
  end

  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign zero      = (r_result == '0);

endmodule
`default_nettype wire
